// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared framebuffer defaults, colour packing and writer FSM states
// FB_RGB565_EN selects 16-bit RGB565 framebuffer words instead of 24-bit RGB888.
package gpu_pkg;

  localparam int unsigned FB_W_DEF = 160;
  localparam int unsigned FB_H_DEF = 120;

`ifdef FB_RGB565_EN
  localparam int unsigned DATA_W = 16;
`else
  localparam int unsigned DATA_W = 24;
`endif

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_t;

  function automatic logic [15:0] rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  function automatic logic [DATA_W-1:0] pack_color(input logic [23:0] c);
`ifdef FB_RGB565_EN
    return rgb565(c);
`else
    return c;
`endif
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous FIFO with head/second-entry peek
// A push into a full FIFO is accepted when a pop happens on the same edge.
module pix_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         second,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Second entry lets the writer issue back-to-back words on the ack edge.
  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - clips rasteriser pixels, queues them and writes the framebuffer
// Word format follows FB_RGB565_EN (16-bit RGB565) or its absence (24-bit RGB888).
module fb_pixel_writer
  import gpu_pkg::*;
#(
  parameter int unsigned FB_W       = FB_W_DEF,
  parameter int unsigned FB_H       = FB_H_DEF,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        px,
  input  logic [7:0]        py,
  input  logic [23:0]       pixel_color,
  input  logic              pixel_valid,
  input  logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        clip_count
);

  localparam int ENTRY_W = int'(ADDR_W + DATA_W);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  wr_state_t          state;
  logic               in_bounds;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] second;
  logic [ENTRY_W-1:0] entry;
  logic [ADDR_W-1:0]  pix_addr;
  logic               done_pending;
  logic               fire;

  assign in_bounds = (32'(px) < FB_W) && (32'(py) < FB_H);
  assign pix_addr  = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
  assign entry     = {pix_addr, pack_color(pixel_color)};

  // The head entry stays in the FIFO until its write is acknowledged.
  assign pop  = (state == WR_WRITE) && mem_ack;
  assign push = pixel_valid && in_bounds && (!fifo_full || pop);
  assign fire = done_pending && fifo_empty && (state == WR_IDLE) && !push;

  pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (int'(FIFO_DEPTH))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (head),
    .second    (second),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WR_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (!fifo_empty) begin
            {mem_addr, mem_wdata} <= head;
            mem_we                <= 1'b1;
            state                 <= WR_WRITE;
          end
        end
        WR_WRITE: begin
          if (mem_ack) begin
            if (fifo_count > CW'(1)) begin
              {mem_addr, mem_wdata} <= second;
            end else begin
              mem_we <= 1'b0;
              state  <= WR_IDLE;
            end
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= WR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count   <= '0;
      overflow     <= 1'b0;
      done_pending <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (pixel_valid && !in_bounds && (clip_count != 8'hFF)) begin
        clip_count <= clip_count + 8'd1;
      end
      if (pixel_valid && in_bounds && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      // A fresh done always re-arms; repeated dones before completion merge.
      done_pending <= done || (done_pending && !fire);
      frame_done   <= fire;
    end
  end

endmodule
